// File: rtl/leaf_refill_scheduler_pkg.sv
// Shared types and default sizing for the leaf refill scheduler.
package leaf_refill_scheduler_pkg;

    localparam int DEF_NUM_LEAVES = 128;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_BURST      = 8;
    localparam int DEF_RUN_LEN    = 1024;
    localparam int DEF_AW         = 32;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_LEAF_W = idx_w(DEF_NUM_LEAVES);
    localparam int DEF_LEN_W  = $clog2(DEF_BURST) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/leaf_refill_scheduler_rr_picker.sv
// Rotating-priority encoder: first eligible index at or after rr_ptr, wrapping.
module leaf_refill_scheduler_rr_picker
    import leaf_refill_scheduler_pkg::*;
#(
    parameter int N  = DEF_NUM_LEAVES,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    // Walk the ring once starting at rr_ptr; the first hit wins.
    always_comb begin
        int j;
        found = 1'b0;
        index = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && eligible[j]) begin
                found = 1'b1;
                index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Credit-based refill scheduler: issues burst read requests for leaf FIFOs
// round-robin, reserving FIFO space and run records when a request is loaded.
module leaf_refill_scheduler
    import leaf_refill_scheduler_pkg::*;
#(
    parameter  int NUM_LEAVES = DEF_NUM_LEAVES,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int BURST      = DEF_BURST,
    parameter  int RUN_LEN    = DEF_RUN_LEN,
    parameter  int AW         = DEF_AW,
    localparam int LW         = idx_w(NUM_LEAVES),
    localparam int LENW       = $clog2(BURST) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [AW-1:0]         i_base_addr,
    input  logic [NUM_LEAVES-1:0] i_leaf_read,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [LW-1:0]         o_req_leaf,
    output logic [AW-1:0]         o_req_addr,
    output logic [LENW-1:0]       o_req_len,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = $clog2(RUN_LEN + 1);

    state_t                state;
    logic [AW-1:0]         base;
    logic [LW-1:0]         rr_ptr;
    logic [CW-1:0]         credit [NUM_LEAVES];
    logic [RW-1:0]         remain [NUM_LEAVES];

    logic [NUM_LEAVES-1:0] eligible;
    logic [NUM_LEAVES-1:0] run_empty;
    logic [NUM_LEAVES-1:0] credit_full;
    logic [NUM_LEAVES-1:0] hit;
    logic                  found;
    logic [LW-1:0]         win;
    logic [RW-1:0]         win_remain;
    logic [LENW-1:0]       win_len;
    logic [AW-1:0]         win_addr;
    logic                  load;
    logic                  start_ok;

    assign start_ok = (state == ST_IDLE) && i_start;

    // Per-leaf status: needy-and-fundable, run exhausted, FIFO fully drained.
    always_comb begin
        eligible    = '0;
        run_empty   = '0;
        credit_full = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            run_empty[i]   = (remain[i] == '0);
            credit_full[i] = (credit[i] == CW'(FIFO_DEPTH));
            eligible[i]    = !run_empty[i] &&
                             (int'(credit[i]) >= ((int'(remain[i]) < BURST) ? int'(remain[i]) : BURST));
        end
    end

    leaf_refill_scheduler_rr_picker #(
        .N  (NUM_LEAVES),
        .IW (LW)
    ) u_rr_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .index    (win)
    );

    // A new request loads when the slot is free or is being consumed this cycle.
    assign load       = (state == ST_RUN) && found && (!o_req_valid || i_req_ready);
    assign win_remain = remain[win];
    assign win_len    = (int'(win_remain) < BURST) ? LENW'(win_remain) : LENW'(BURST);
    assign win_addr   = base + AW'(win) * AW'(RUN_LEN) + AW'(RUN_LEN) - AW'(win_remain);

    // One-hot of the leaf whose credit and remain are reserved this cycle.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            hit[i] = load && (win == LW'(i));
        end
    end

    // Credit and remaining-record bookkeeping; reservation and return combine unclamped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                credit[i] <= CW'(FIFO_DEPTH);
                remain[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (start_ok) begin
                    credit[i] <= CW'(FIFO_DEPTH);
                    remain[i] <= RW'(RUN_LEN);
                end else begin
                    credit[i] <= credit[i] - (hit[i] ? CW'(win_len) : CW'(0)) + CW'(i_leaf_read[i]);
                    if (hit[i]) remain[i] <= remain[i] - RW'(win_len);
                end
            end
        end
    end

    // Control FSM plus the registered request slot and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            base        <= '0;
            rr_ptr      <= '0;
            o_req_valid <= 1'b0;
            o_req_leaf  <= '0;
            o_req_addr  <= '0;
            o_req_len   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        base   <= i_base_addr;
                        o_busy <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((&run_empty) && !o_req_valid) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (&credit_full) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (load) begin
                o_req_valid <= 1'b1;
                o_req_leaf  <= win;
                o_req_addr  <= win_addr;
                o_req_len   <= win_len;
                rr_ptr      <= (int'(win) == NUM_LEAVES - 1) ? '0 : win + LW'(1);
            end else if (i_req_ready) begin
                o_req_valid <= 1'b0;
            end
        end
    end

    // A leaf strobe must never return credit beyond the FIFO capacity.
    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_credit_chk
        a_credit_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
            !(i_leaf_read[g] && !hit[g] && !start_ok && (credit[g] == CW'(FIFO_DEPTH))));
    end

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Directed bench for leaf_refill_scheduler on a 4-leaf, 20-record-run configuration.
module tb_leaf_refill_scheduler;

    localparam int NL   = 4;
    localparam int FD   = 16;
    localparam int BU   = 8;
    localparam int RL   = 20;
    localparam int AW   = 32;
    localparam int LW   = 2;
    localparam int LENW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = 32'h100;
    logic [NL-1:0]   leaf_read = '0;
    logic            req_ready = 1'b0;
    logic            req_valid;
    logic [LW-1:0]   req_leaf;
    logic [AW-1:0]   req_addr;
    logic [LENW-1:0] req_len;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    leaf_refill_scheduler #(
        .NUM_LEAVES (NL),
        .FIFO_DEPTH (FD),
        .BURST      (BU),
        .RUN_LEN    (RL),
        .AW         (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_leaf_read (leaf_read),
        .o_req_valid (req_valid),
        .i_req_ready (req_ready),
        .o_req_leaf  (req_leaf),
        .o_req_addr  (req_addr),
        .o_req_len   (req_len),
        .o_busy      (busy),
        .o_done      (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_strobe = 0;
    bit prompt = 1'b0;
    int occ [NL];
    int q_leaf [$];
    int q_addr [$];
    int q_len  [$];
    int q_cyc  [$];

    // Log the handshake finishing this cycle, advance one clock, then (in prompt
    // mode) drain one record per leaf per cycle from everything already accepted.
    task automatic step();
        if (req_valid && req_ready) begin
            q_leaf.push_back(int'(req_leaf));
            q_addr.push_back(int'(req_addr));
            q_len.push_back(int'(req_len));
            q_cyc.push_back(cyc);
            if (prompt) occ[req_leaf] += int'(req_len);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (prompt) begin
            for (int i = 0; i < NL; i++) begin
                if (occ[i] > 0) begin
                    leaf_read[i] = 1'b1;
                    occ[i]--;
                    last_strobe = cyc;
                end else begin
                    leaf_read[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        leaf_read = '0;
        req_ready = 1'b0;
        prompt = 1'b0;
        base_addr = 32'h100;
        for (int i = 0; i < NL; i++) occ[i] = 0;
        q_leaf.delete(); q_addr.delete(); q_len.delete(); q_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Pulse start in cycle 0; returns sampled in cycle 1.
    task automatic kick();
        cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({req_valid, req_leaf, req_addr, req_len, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_values: got v=%0b leaf=%0h addr=%0h len=%0h busy=%0b done=%0b want all 0",
                     req_valid, req_leaf, req_addr, req_len, busy, done);
        end
        req_ready = 1'b1;
        kick();
        step(); step();
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_precond_valid: got %0b want 1", req_valid);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if ({req_valid, req_leaf, req_addr, req_len, busy, done} !== '0) begin
            bad++;
            $display("FAIL async_reset: got v=%0b leaf=%0h addr=%0h len=%0h busy=%0b done=%0b want all 0",
                     req_valid, req_leaf, req_addr, req_len, busy, done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            total++;
            if ({req_valid, busy} !== 2'b00) begin
                bad++;
                $display("FAIL idle_after_reset: cycle %0d got valid=%0b busy=%0b want 0 0", n, req_valid, busy);
            end
        end
    endtask

    task automatic test_burst_split();
        int exp_leaf [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        int l1_idx   [3]  = '{1, 5, 9};
        int l1_len   [3]  = '{8, 8, 4};
        int l1_addr  [3]  = '{32'h114, 32'h11C, 32'h124};
        bit seen_done;
        bit prev_busy;
        int done_cyc;
        do_reset();
        prompt = 1'b1;
        req_ready = 1'b1;
        kick();
        total++;
        if ({busy, req_valid} !== 2'b10) begin
            bad++;
            $display("FAIL start_latency_c1: got busy=%0b valid=%0b want 1 0", busy, req_valid);
        end
        step();
        total++;
        if ({req_valid, req_leaf, req_addr, req_len} !== {1'b1, 2'd0, 32'h100, 4'd8}) begin
            bad++;
            $display("FAIL first_request_c2: got v=%0b leaf=%0d addr=%0h len=%0d want 1 0 100 8",
                     req_valid, req_leaf, req_addr, req_len);
        end
        seen_done = 1'b0;
        prev_busy = busy;
        done_cyc = 0;
        for (int n = 0; n < 100 && !seen_done; n++) begin
            prev_busy = busy;
            step();
            if (done === 1'b1) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
        end
        total++;
        if (seen_done !== 1'b1) begin
            bad++;
            $display("FAIL done_seen: got no o_done within 100 cycles want a pulse");
        end
        total++;
        if (q_leaf.size() != 12) begin
            bad++;
            $display("FAIL split_req_count: got %0d want 12", q_leaf.size());
        end
        for (int k = 0; k < 12 && k < q_leaf.size(); k++) begin
            total++;
            if (q_leaf[k] != exp_leaf[k]) begin
                bad++;
                $display("FAIL split_leaf_order[%0d]: got %0d want %0d", k, q_leaf[k], exp_leaf[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (l1_idx[k] < q_leaf.size()) begin
                total++;
                if (q_len[l1_idx[k]] != l1_len[k] || q_addr[l1_idx[k]] != l1_addr[k]) begin
                    bad++;
                    $display("FAIL leaf1_burst[%0d]: got len=%0d addr=%0h want len=%0d addr=%0h",
                             k, q_len[l1_idx[k]], q_addr[l1_idx[k]], l1_len[k], l1_addr[k]);
                end
            end
        end
        if (q_cyc.size() == 12) begin
            total++;
            if (q_cyc[11] != 13) begin
                bad++;
                $display("FAIL back_to_back: last handshake cycle got %0d want 13", q_cyc[11]);
            end
        end
        total++;
        if (done_cyc != last_strobe + 2) begin
            bad++;
            $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_strobe + 2);
        end
        total++;
        if ({prev_busy, busy} !== 2'b10) begin
            bad++;
            $display("FAIL busy_falls_with_done: got before=%0b at=%0b want 1 0", prev_busy, busy);
        end
        step();
        total++;
        if ({done, busy, req_valid} !== 3'b000) begin
            bad++;
            $display("FAIL done_one_cycle: got done=%0b busy=%0b valid=%0b want 0 0 0", done, busy, req_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [LW-1:0]   s_leaf;
        logic [AW-1:0]   s_addr;
        logic [LENW-1:0] s_len;
        int exp_leaf [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        kick();
        step();
        s_leaf = req_leaf; s_addr = req_addr; s_len = req_len;
        total++;
        if ({req_valid, s_leaf, s_addr, s_len} !== {1'b1, 2'd0, 32'h100, 4'd8}) begin
            bad++;
            $display("FAIL bp_first: got v=%0b leaf=%0d addr=%0h len=%0d want 1 0 100 8",
                     req_valid, s_leaf, s_addr, s_len);
        end
        for (int n = 0; n < 10; n++) begin
            step();
            total++;
            if ({req_valid, req_leaf, req_addr, req_len} !== {1'b1, 2'd0, 32'h100, 4'd8}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%0b leaf=%0d addr=%0h len=%0d want 1 0 100 8",
                         n, req_valid, req_leaf, req_addr, req_len);
            end
        end
        req_ready = 1'b1;
        repeat (20) step();
        total++;
        if (q_leaf.size() != 8) begin
            bad++;
            $display("FAIL bp_req_count: got %0d want 8", q_leaf.size());
        end
        for (int k = 0; k < 8 && k < q_leaf.size(); k++) begin
            total++;
            if (q_leaf[k] != exp_leaf[k]) begin
                bad++;
                $display("FAIL bp_leaf_order[%0d]: got %0d want %0d", k, q_leaf[k], exp_leaf[k]);
            end
        end
        if (q_addr.size() > 1) begin
            total++;
            if (q_addr[1] != 32'h114) begin
                bad++;
                $display("FAIL bp_second_addr: got %0h want 114", q_addr[1]);
            end
        end
    endtask

    task automatic test_credit_stall();
        do_reset();
        req_ready = 1'b1;
        kick();
        repeat (19) step();
        total++;
        if (q_leaf.size() != 8 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_two_bursts: got count=%0d valid=%0b want 8 0", q_leaf.size(), req_valid);
        end
        leaf_read = 4'b0100;
        step();
        leaf_read = '0;
        repeat (6) step();
        total++;
        if (q_leaf.size() != 8 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_one_strobe: got count=%0d valid=%0b want 8 0", q_leaf.size(), req_valid);
        end
        leaf_read = 4'b0100;
        repeat (3) step();
        leaf_read = '0;
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_reenable_early: got valid=%0b want 0", req_valid);
        end
        step();
        total++;
        if ({req_valid, req_leaf, req_addr, req_len} !== {1'b1, 2'd2, 32'h138, 4'd4}) begin
            bad++;
            $display("FAIL stall_reenable: got v=%0b leaf=%0d addr=%0h len=%0d want 1 2 138 4",
                     req_valid, req_leaf, req_addr, req_len);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_ready = 1'b1;
        kick();
        leaf_read = 4'b0001;
        step();
        leaf_read = '0;
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        total++;
        if (q_leaf.size() != 8 || busy !== 1'b1 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL sim_start_ignored: got count=%0d busy=%0b valid=%0b want 8 1 0",
                     q_leaf.size(), busy, req_valid);
        end
        leaf_read = 4'b0001;
        repeat (2) step();
        leaf_read = '0;
        repeat (5) step();
        total++;
        if (q_leaf.size() != 8 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL sim_credit_nine: got count=%0d valid=%0b want 8 0", q_leaf.size(), req_valid);
        end
        leaf_read = 4'b0001;
        step();
        leaf_read = '0;
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL sim_reenable_early: got valid=%0b want 0", req_valid);
        end
        step();
        total++;
        if ({req_valid, req_leaf, req_addr, req_len} !== {1'b1, 2'd0, 32'h110, 4'd4}) begin
            bad++;
            $display("FAIL sim_reenable: got v=%0b leaf=%0d addr=%0h len=%0d want 1 0 110 4",
                     req_valid, req_leaf, req_addr, req_len);
        end
    endtask

    initial begin
        test_reset();
        test_burst_split();
        test_backpressure();
        test_credit_stall();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
